// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Two-requester round-robin arbiter in front of one port of the dual-port
//   RAM wrapper. Each transfer takes one ACCESS cycle, which drives the RAM
//   port, and one RESP cycle, which returns ack/rdat to the winning requester.
//   The RESP cycle covers the RAM's registered read data and range-active flag.
//
// Parameters
//   AW  address width (requesters and RAM port)
//   DW  data width
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   stb/we/adr/wdat{0,1}    requester strobe (held until ack), write enable,
//                           address, write data
//   ack{0,1}, rdat{0,1}     one-cycle completion and read data (0 on writes)
//   ram_en/we/addr/din      RAM port command, driven only in ACCESS
//   ram_dout, ram_act       RAM read data and range-active flag (valid in RESP)
//   busy                    high in ACCESS or RESP
//   err{0,1}                only with RAM_PORT_ARBITER_ERR_EN: out-of-range
//                           access flag, pulsed with ack
//
// Optional feature macro: RAM_PORT_ARBITER_ERR_EN
module ram_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stb0,
  input  logic          we0,
  input  logic [AW-1:0] adr0,
  input  logic [DW-1:0] wdat0,
  output logic          ack0,
  output logic [DW-1:0] rdat0,
  input  logic          stb1,
  input  logic          we1,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdat1,
  output logic          ack1,
  output logic [DW-1:0] rdat1,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic          ram_act,
  output logic          busy
`ifdef RAM_PORT_ARBITER_ERR_EN
  ,
  output logic          err0,
  output logic          err1
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Granted requester's command, and the other requester's strobe
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wdat;
  logic          other_stb;

  always_comb begin
    sel_we    = gnt_q ? we1   : we0;
    sel_adr   = gnt_q ? adr1  : adr0;
    sel_wdat  = gnt_q ? wdat1 : wdat0;
    other_stb = gnt_q ? stb0  : stb1;
  end

  logic [DW-1:0] resp_data;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdat0     = '0;
    rdat1     = '0;
    resp_data = '0;
`ifdef RAM_PORT_ARBITER_ERR_EN
    err0      = 1'b0;
    err1      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (stb0 || stb1) begin
          state_d = ACCESS;
          if (stb0 && stb1) gnt_d = ~last_q;
          else              gnt_d = stb1;
        end
      end

      ACCESS: begin
        ram_en   = 1'b1;
        ram_we   = sel_we;
        ram_addr = sel_adr;
        ram_din  = sel_wdat;
        state_d  = RESP;
      end

      RESP: begin
        resp_data = sel_we ? '0 : ram_dout;
        if (gnt_q) begin
          ack1  = 1'b1;
          rdat1 = resp_data;
        end else begin
          ack0  = 1'b1;
          rdat0 = resp_data;
        end
`ifdef RAM_PORT_ARBITER_ERR_EN
        if (gnt_q) err1 = ~ram_act;
        else       err0 = ~ram_act;
`endif
        last_d = gnt_q;
        // The granted strobe is deliberately ignored here: that requester
        // is being acked, so only the other side can chain back-to-back.
        if (other_stb) begin
          gnt_d   = ~gnt_q;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifndef RAM_PORT_ARBITER_ERR_EN
  // Range flag only matters when error reporting is built in
  logic unused_ram_act;
  assign unused_ram_act = ram_act;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned WIN = 256;  // RAM window: word addresses 0..255

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    stb = '0;
  logic [1:0]    we = '0;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat [2];
  logic          ack0, ack1;
  logic [DW-1:0] rdat0, rdat1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_act;
  logic          busy;
`ifdef RAM_PORT_ARBITER_ERR_EN
  logic          err0, err1;
`endif

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .stb0     (stb[0]),
    .we0      (we[0]),
    .adr0     (adr[0]),
    .wdat0    (wdat[0]),
    .ack0     (ack0),
    .rdat0    (rdat0),
    .stb1     (stb[1]),
    .we1      (we[1]),
    .adr1     (adr[1]),
    .wdat1    (wdat[1]),
    .ack1     (ack1),
    .rdat1    (rdat1),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .ram_act  (ram_act),
    .busy     (busy)
`ifdef RAM_PORT_ARBITER_ERR_EN
    ,
    .err0     (err0),
    .err1     (err1)
`endif
  );

  // RAM wrapper stand-in: registered read, zero output when idle/writing,
  // range flag registered one cycle after the address, full-width decode.
  logic [DW-1:0] mem [WIN];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_dout <= '0;
      ram_act  <= 1'b0;
    end else begin
      ram_act  <= ram_en && (ram_addr < WIN);
      ram_dout <= (ram_en && !ram_we && (ram_addr < WIN)) ? mem[ram_addr[7:0]] : '0;
      if (ram_en && ram_we && (ram_addr < WIN)) mem[ram_addr[7:0]] <= ram_din;
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] rdat;
    logic          err;
  } exp_t;
  typedef struct {
    int unsigned r;
    int unsigned t;
  } ev_t;

  exp_t          sbq0[$];
  exp_t          sbq1[$];
  ev_t           log_q[$];
  logic [DW-1:0] ref_mem [WIN];
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int r, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    exp_t e;
    bit   inr;
    inr   = (a < WIN);
    e.err = !inr;
    if (w) begin
      e.rdat = '0;
      if (inr) ref_mem[a[7:0]] = d;
    end else begin
      e.rdat = inr ? ref_mem[a[7:0]] : '0;
    end
    if (r == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  // Called just after a rising edge; returns just after a rising edge
  task automatic xfer(input int r, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int exp_lat);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    push_exp(r, w, a, d);
    we[r]   = w;
    adr[r]  = a;
    wdat[r] = d;
    stb[r]  = 1'b1;
    while (!got && lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      got = (r == 0) ? ack0 : ack1;
    end
    check($sformatf("ack%0d_seen", r), 64'(got), 64'd1);
    if (exp_lat > 0) check($sformatf("lat%0d", r), 64'(lat), 64'(exp_lat));
    @(posedge clk);
    #1;
    stb[r] = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (!ram_en) begin
          check("idle_addr", 64'(ram_addr), 64'd0);
          check("idle_din_we", 64'({ram_we, ram_din}), 64'd0);
        end
        if (!ack0) check("rdat0_ungranted", 64'(rdat0), 64'd0);
        if (!ack1) check("rdat1_ungranted", 64'(rdat1), 64'd0);
`ifdef RAM_PORT_ARBITER_ERR_EN
        if (!ack0) check("err0_ungranted", 64'(err0), 64'd0);
        if (!ack1) check("err1_ungranted", 64'(err1), 64'd0);
`endif
        if (ack0 || ack1) begin
          check("ack_onehot", 64'(ack0 & ack1), 64'd0);
          log_q.push_back('{r: (ack1 ? 1 : 0), t: cyc});
        end
        if (ack0) begin
          check("sb0_pending", 64'(sbq0.size() != 0), 64'd1);
          if (sbq0.size() != 0) begin
            e = sbq0.pop_front();
            check("rdat0", 64'(rdat0), 64'(e.rdat));
`ifdef RAM_PORT_ARBITER_ERR_EN
            check("err0", 64'(err0), 64'(e.err));
`endif
          end
        end
        if (ack1) begin
          check("sb1_pending", 64'(sbq1.size() != 0), 64'd1);
          if (sbq1.size() != 0) begin
            e = sbq1.pop_front();
            check("rdat1", 64'(rdat1), 64'(e.rdat));
`ifdef RAM_PORT_ARBITER_ERR_EN
            check("err1", 64'(err1), 64'(e.err));
`endif
          end
        end
      end
    end
  endtask

  int unsigned t0;
  int unsigned n1;

  initial begin
    adr[0]  = '0;
    adr[1]  = '0;
    wdat[0] = '0;
    wdat[1] = '0;
    mem[8'h10]     <= 32'hDEAD_BEEF;
    ref_mem[8'h10]  = 32'hDEAD_BEEF;

    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 64'(ack0), 64'd0);
    check("rst_ack1", 64'(ack1), 64'd0);
    check("rst_ram_en", 64'(ram_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_rdat0", 64'(rdat0), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read with cycle-exact timing
    log_q.delete();
    push_exp(0, 1'b0, 32'h10, '0);
    we[0]  = 1'b0;
    adr[0] = 32'h10;
    stb[0] = 1'b1;
    @(negedge clk);
    check("c0_ram_en", 64'(ram_en), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("c1_ram_en", 64'(ram_en), 64'd1);
    check("c1_addr", 64'(ram_addr), 64'h10);
    check("c1_we", 64'(ram_we), 64'd0);
    check("c1_busy", 64'(busy), 64'd1);
    check("c1_ack0", 64'(ack0), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("c2_ack0", 64'(ack0), 64'd1);
    check("c2_rdat0", 64'(rdat0), 64'hDEAD_BEEF);
    check("c2_ram_en", 64'(ram_en), 64'd0);
    @(posedge clk);
    #1 stb[0] = 1'b0;
    @(negedge clk);
    check("c3_busy", 64'(busy), 64'd0);
    check("c3_ack0", 64'(ack0), 64'd0);
    n1 = 0;
    foreach (log_q[i]) if (log_q[i].r == 1) n1++;
    check("single_no_ack1", 64'(n1), 64'd0);
    @(posedge clk);
    #1;

    // Write then read, requester 1; window edges; full-width address
    xfer(1, 1'b1, 32'h20, 32'h1234_5678, 2);
    xfer(1, 1'b0, 32'h20, '0, 2);
    xfer(0, 1'b1, 32'hFF, 32'hA5A5_0F0F, 2);
    xfer(0, 1'b0, 32'hFF, '0, 2);
    xfer(1, 1'b1, 32'h8000_0010, 32'h0BAD_0BAD, 2);
    xfer(0, 1'b0, 32'h10, '0, 2);
    xfer(0, 1'b0, 32'h100, '0, 2);
    xfer(0, 1'b0, 32'h0000_1000, '0, 2);

    // Contention from reset release: strict alternation every 2 cycles
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    log_q.delete();
    reset_n = 1'b1;
    t0 = cyc;
    fork
      begin
        for (int unsigned i = 0; i < 4; i++)
          xfer(0, 1'b1, 32'h40 + i, 32'hC0DE_0000 + i, 0);
      end
      begin
        for (int unsigned i = 0; i < 4; i++)
          xfer(1, 1'b0, 32'h10, '0, 0);
      end
    join
    check("cont_nacks", 64'(log_q.size()), 64'd8);
    foreach (log_q[i]) begin
      check($sformatf("cont_gnt%0d", i), 64'(log_q[i].r), 64'(i % 2));
      check($sformatf("cont_cyc%0d", i), 64'(log_q[i].t - t0), 64'(2 * (i + 1)));
    end
    xfer(1, 1'b0, 32'h42, '0, 2);

    // Fairness after lone use of requester 1
    xfer(1, 1'b0, 32'h41, '0, 2);
    log_q.delete();
    fork
      xfer(0, 1'b0, 32'h43, '0, 0);
      xfer(1, 1'b0, 32'h20, '0, 0);
    join
    check("fair_n", 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      check("fair_first", 64'(log_q[0].r), 64'd0);
      check("fair_second", 64'(log_q[1].r), 64'd1);
    end

    // Reset asserted during ACCESS
    we[0]  = 1'b0;
    adr[0] = 32'h10;
    stb[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_access", 64'(ram_en), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_ram_en", 64'(ram_en), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstmid_ack0", 64'(ack0), 64'd0);
    check("rstmid_ram_en2", 64'(ram_en), 64'd0);
    stb[0] = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    xfer(0, 1'b0, 32'h10, '0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb0_drained", 64'(sbq0.size()), 64'd0);
    check("sb1_drained", 64'(sbq1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares one port of the dual-port RAM wrapper.
- Typical pairing: CPU data path and a DMA/loader.
- Sequences each transfer as a fixed ACCESS/RESP pair, matching the RAM's one-cycle registered read and range-active latency.
- Returns read data and a one-cycle acknowledge to the winning requester.

Parameters:
- AW, 32, address width of requesters and RAM port.
- DW, 32, data width.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- stb0  in  1  requester 0 strobe; held until ack0.
- we0  in  1  requester 0 write enable.
- adr0  in  AW  requester 0 address.
- wdat0  in  DW  requester 0 write data.
- ack0  out  1  requester 0 transfer complete, one cycle.
- rdat0  out  DW  requester 0 read data, valid with ack0.
- stb1, we1, adr1, wdat1, ack1, rdat1: same as requester 0, for requester 1.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  AW  RAM port address.
- ram_din  out  DW  RAM port write data.
- ram_dout  in  DW  RAM port read data; already zeroed by the RAM when inactive or writing.
- ram_act  in  1  RAM range-active flag, registered one cycle after address.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, gnt=0, last=1, so requester 0 wins first tie.
  - All outputs 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No stb: stay.
  - One stb: gnt=that requester, go ACCESS.
  - Both stb: gnt=!last, go ACCESS.
- ACCESS (one cycle):
  - ram_en=1, ram_we=we[gnt], ram_addr=adr[gnt], ram_din=wdat[gnt].
  - Go RESP.
- RESP (one cycle):
  - ram_en=0, ack[gnt]=1.
  - rdat[gnt]=ram_dout when we[gnt]=0, else 0.
  - last<=gnt.
  - If stb[!gnt]=1: gnt<=!gnt, go ACCESS (back-to-back).
  - Else go IDLE.
  - stb[gnt] is ignored this cycle because the requester is being acked.
- Latency: stb high in IDLE at cycle 0 -> ACCESS in cycle 1 -> ack in cycle 2.
- Throughput: one transfer per 2 cycles under continuous contention, alternating strictly.
- Outputs are driven only for the granted requester:
  - non-granted ack=0, rdat=0;
  - ram_addr/ram_din/ram_we=0 outside ACCESS.
- Requesters hold we/adr/wdat stable from stb rise until ack. The arbiter samples them combinationally in ACCESS and RESP.
- stb dropped before ack (protocol violation): the transfer still completes and ack still pulses; no hang.
- Reset asserted mid-transfer: immediate return to IDLE, ack suppressed, RAM write may or may not have committed.
- Address is passed through untruncated at full AW bits; range decode belongs to the RAM wrapper.

Optional Feature:
- Macro: RAM_PORT_ARBITER_ERR_EN.
- Defined:
  - Adds outputs err0 and err1 (1 bit each).
  - In RESP, err[gnt]=!ram_act, asserted alongside ack.
  - err reset value 0, otherwise 0.
  - Flags out-of-range accesses for a bus fault.
- Undefined:
  - No err ports.
  - Out-of-range reads ack normally with rdat=0 (zero from the RAM wrapper).
  - Out-of-range writes are silently dropped by the RAM.

Test Plan:
- Single read: RAM[0x10]=0xDEADBEEF; stb0=1, we0=0, adr0=0x10 at cycle 0 -> ram_en=1 in cycle 1; ack0=1, rdat0=0xDEADBEEF in cycle 2; ack1 never asserted.
- Write then read: requester 1 writes 0x12345678 to 0x20, then reads 0x20 -> write ack1 at cycle 2 with rdat1=0; read returns 0x12345678.
- Contention: stb0 and stb1 both held continuously from reset release, each for 4 transfers -> grants 0,1,0,1,...; acks in cycles 2,4,6,8,...; each requester gets exactly 4 acks in 16 cycles.
- Fairness after lone use: requester 1 completes alone, then both request together -> requester 0 is granted first.
- Reset mid-transfer: reset_n low during ACCESS -> next cycle state IDLE, ram_en=0, no ack; after release, a fresh request completes normally in 2 cycles.
- With RAM_PORT_ARBITER_ERR_EN, read address outside the RAM window (ram_act=0) -> ack0=1, err0=1, rdat0=0. Without the macro -> ack0=1, rdat0=0.
